// File: rtl/alarm_unit.sv
// ---------------------------------------------------------------------------
// alarm_unit
//
// Alarm stage that sits behind the sec/min/hour BCD time counters. It holds a
// user-programmable alarm time (HH:MM in BCD), rings when the running time
// reaches HH:MM:00 while armed, and supports snooze, stop and an automatic
// ring timeout. The alarm digits are always visible on the AL* outputs so the
// display mux can show them while the user is setting the alarm.
//
// Ports:
//   CLK, RST            system clock, asynchronous active-low reset
//   EN1HZ               one-cycle tick per second from the prescaler
//   QLsec..QHhour       running time digits (BCD)
//   KEY_SET/HOUR/MIN    active-low buttons: toggle set mode, alarm hour +1,
//                       alarm minute +1
//   KEY_STOP/KEY_SNZ    active-low buttons: stop ring/snooze, snooze
//   SW_ARM              level switch, 1 = alarm armed
//   ALQLmin..ALQHhour   alarm time digits (BCD)
//   SETMODE/RING/SNOOZING  registered state indicators
// ---------------------------------------------------------------------------
module alarm_unit #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic [3:0] QLsec,
    input  logic [2:0] QHsec,
    input  logic [3:0] QLmin,
    input  logic [2:0] QHmin,
    input  logic [3:0] QLhour,
    input  logic [1:0] QHhour,
    input  logic       KEY_SET,
    input  logic       KEY_HOUR,
    input  logic       KEY_MIN,
    input  logic       KEY_STOP,
    input  logic       KEY_SNZ,
    input  logic       SW_ARM,
    output logic [3:0] ALQLmin,
    output logic [2:0] ALQHmin,
    output logic [3:0] ALQLhour,
    output logic [1:0] ALQHhour,
    output logic       SETMODE,
    output logic       RING,
    output logic       SNOOZING
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SET,
        S_RINGING,
        S_SNOOZE
    } state_t;

    localparam int K_SET  = 0;
    localparam int K_HOUR = 1;
    localparam int K_MIN  = 2;
    localparam int K_STOP = 3;
    localparam int K_SNZ  = 4;

    localparam logic [8:0] RING_LIMIT   = 9'(RING_SECS);
    localparam logic [8:0] SNOOZE_LIMIT = 9'(SNOOZE_SECS);

    logic [4:0] keys_raw;
    logic [4:0] key_s1_q,   key_s1_d;
    logic [4:0] key_s2_q,   key_s2_d;
    logic [4:0] key_prev_q, key_prev_d;
    logic [4:0] press_q,    press_d;
    logic       arm_s1_q,   arm_s1_d;
    logic       arm_s2_q,   arm_s2_d;
    logic       match_q,    match_d;
    state_t     state_q,    state_d;
    logic [8:0] cnt_q,      cnt_d;
    logic [3:0] al_ql_min_q,  al_ql_min_d;
    logic [2:0] al_qh_min_q,  al_qh_min_d;
    logic [3:0] al_ql_hour_q, al_ql_hour_d;
    logic [1:0] al_qh_hour_q, al_qh_hour_d;
    logic       setmode_q,  setmode_d;
    logic       ring_q,     ring_d;
    logic       snoozing_q, snoozing_d;

    logic       match;
    logic       match_rise;
    logic       arm;
    logic [8:0] cnt_inc;

    // Minute digits count 00..59 and wrap without touching the hour.
    function automatic logic [6:0] inc_min(input logic [2:0] hi, input logic [3:0] lo);
        logic [2:0] r_hi;
        logic [3:0] r_lo;
        if (lo == 4'd9) begin
            r_lo = 4'd0;
            r_hi = (hi == 3'd5) ? 3'd0 : hi + 3'd1;
        end else begin
            r_lo = lo + 4'd1;
            r_hi = hi;
        end
        return {r_hi, r_lo};
    endfunction

    // Hour digits count 00..23; the ones digit rolls at 9 except at 23.
    function automatic logic [5:0] inc_hour(input logic [1:0] hi, input logic [3:0] lo);
        logic [1:0] r_hi;
        logic [3:0] r_lo;
        if (hi == 2'd2 && lo == 4'd3) begin
            r_hi = 2'd0;
            r_lo = 4'd0;
        end else if (lo == 4'd9) begin
            r_hi = hi + 2'd1;
            r_lo = 4'd0;
        end else begin
            r_hi = hi;
            r_lo = lo + 4'd1;
        end
        return {r_hi, r_lo};
    endfunction

    assign keys_raw = {KEY_SNZ, KEY_STOP, KEY_MIN, KEY_HOUR, KEY_SET};
    assign arm      = arm_s2_q;

    assign match = (QHhour == al_qh_hour_q) && (QLhour == al_ql_hour_q) &&
                   (QHmin  == al_qh_min_q)  && (QLmin  == al_ql_min_q)  &&
                   (QHsec  == 3'd0)         && (QLsec  == 4'd0);

    // Only the first cycle of a match counts, so arming while the time is
    // already parked on HH:MM:00 never rings.
    assign match_rise = match && !match_q;

    assign cnt_inc = cnt_q + 9'd1;

    always_comb begin
        key_s1_d     = keys_raw;
        key_s2_d     = key_s1_q;
        key_prev_d   = key_s2_q;
        // Falling edge of the synchronised key, registered once more so the
        // press pulse is a clean flop output.
        press_d      = key_prev_q & ~key_s2_q;
        arm_s1_d     = SW_ARM;
        arm_s2_d     = arm_s1_q;
        match_d      = match;
        state_d      = state_q;
        cnt_d        = cnt_q;
        al_ql_min_d  = al_ql_min_q;
        al_qh_min_d  = al_qh_min_q;
        al_ql_hour_d = al_ql_hour_q;
        al_qh_hour_d = al_qh_hour_q;

        unique case (state_q)
            S_IDLE: begin
                if (press_q[K_SET]) begin
                    state_d = S_SET;
                end else if (match_rise && arm) begin
                    state_d = S_RINGING;
                end
            end
            S_SET: begin
                if (press_q[K_HOUR]) begin
                    {al_qh_hour_d, al_ql_hour_d} = inc_hour(al_qh_hour_q, al_ql_hour_q);
                end
                if (press_q[K_MIN]) begin
                    {al_qh_min_d, al_ql_min_d} = inc_min(al_qh_min_q, al_ql_min_q);
                end
                if (press_q[K_SET]) begin
                    state_d = S_IDLE;
                end
            end
            S_RINGING: begin
                if (press_q[K_STOP]) begin
                    state_d = S_IDLE;
                end else if (press_q[K_SNZ]) begin
                    state_d = S_SNOOZE;
                end else if (press_q[K_SET]) begin
                    state_d = S_SET;
                end else if (!arm) begin
                    state_d = S_IDLE;
                end else if (EN1HZ) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == RING_LIMIT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SNOOZE: begin
                if (press_q[K_STOP]) begin
                    state_d = S_IDLE;
                end else if (press_q[K_SET]) begin
                    state_d = S_SET;
                end else if (!arm) begin
                    state_d = S_IDLE;
                end else if (EN1HZ) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SNOOZE_LIMIT) begin
                        state_d = S_RINGING;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state starts its own timing window from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        setmode_d  = (state_d == S_SET);
        ring_d     = (state_d == S_RINGING);
        snoozing_d = (state_d == S_SNOOZE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            key_prev_q   <= '1;
            press_q      <= '0;
            arm_s1_q     <= 1'b0;
            arm_s2_q     <= 1'b0;
            match_q      <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            al_ql_min_q  <= '0;
            al_qh_min_q  <= '0;
            al_ql_hour_q <= '0;
            al_qh_hour_q <= '0;
            setmode_q    <= 1'b0;
            ring_q       <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            key_prev_q   <= key_prev_d;
            press_q      <= press_d;
            arm_s1_q     <= arm_s1_d;
            arm_s2_q     <= arm_s2_d;
            match_q      <= match_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            al_ql_min_q  <= al_ql_min_d;
            al_qh_min_q  <= al_qh_min_d;
            al_ql_hour_q <= al_ql_hour_d;
            al_qh_hour_q <= al_qh_hour_d;
            setmode_q    <= setmode_d;
            ring_q       <= ring_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign ALQLmin  = al_ql_min_q;
    assign ALQHmin  = al_qh_min_q;
    assign ALQLhour = al_ql_hour_q;
    assign ALQHhour = al_qh_hour_q;
    assign SETMODE  = setmode_q;
    assign RING     = ring_q;
    assign SNOOZING = snoozing_q;

endmodule

// File: tb/tb_alarm_unit.sv
// ---------------------------------------------------------------------------
// tb_alarm_unit
//
// Self-checking bench for alarm_unit. Expected output words are pushed onto a
// scoreboard queue when stimulus is launched and popped when the outputs are
// sampled. Alarm programming is table driven; ring, snooze, arm and reset
// corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alarm_unit;

    localparam int K_SET      = 0;
    localparam int K_HOUR     = 1;
    localparam int K_MIN      = 2;
    localparam int K_STOP     = 3;
    localparam int K_SNZ      = 4;
    localparam int K_HOUR_MIN = 5;
    localparam int K_STOP_SNZ = 6;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN1HZ;
    logic [3:0] QLsec;
    logic [2:0] QHsec;
    logic [3:0] QLmin;
    logic [2:0] QHmin;
    logic [3:0] QLhour;
    logic [1:0] QHhour;
    logic       KEY_SET, KEY_HOUR, KEY_MIN, KEY_STOP, KEY_SNZ;
    logic       SW_ARM;
    logic [3:0] ALQLmin;
    logic [2:0] ALQHmin;
    logic [3:0] ALQLhour;
    logic [1:0] ALQHhour;
    logic       SETMODE, RING, SNOOZING;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        string name;
        int    key;
        int    reps;
        int    hh;
        int    mm;
        bit    setm;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    alarm_unit #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
        .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ),
        .QLsec(QLsec), .QHsec(QHsec), .QLmin(QLmin), .QHmin(QHmin),
        .QLhour(QLhour), .QHhour(QHhour),
        .KEY_SET(KEY_SET), .KEY_HOUR(KEY_HOUR), .KEY_MIN(KEY_MIN),
        .KEY_STOP(KEY_STOP), .KEY_SNZ(KEY_SNZ), .SW_ARM(SW_ARM),
        .ALQLmin(ALQLmin), .ALQHmin(ALQHmin), .ALQLhour(ALQLhour), .ALQHhour(ALQHhour),
        .SETMODE(SETMODE), .RING(RING), .SNOOZING(SNOOZING)
    );

    // 100 MHz style clock; the bench drives and samples on the falling edge.
    always #5 CLK = ~CLK;

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds the expected output word from plain decimal time values.
    function automatic logic [15:0] mkExp(input int h, input int m, input bit s,
                                          input bit r, input bit z);
        logic [1:0] hh;
        logic [3:0] hl;
        logic [2:0] mh;
        logic [3:0] ml;
        hh = 2'(h / 10);
        hl = 4'(h % 10);
        mh = 3'(m / 10);
        ml = 4'(m % 10);
        return {hh, hl, mh, ml, s, r, z};
    endfunction

    function automatic logic [15:0] outWord();
        return {ALQHhour, ALQLhour, ALQHmin, ALQLmin, SETMODE, RING, SNOOZING};
    endfunction

    task automatic addVec(input string name, input int key, input int reps,
                          input int hh, input int mm, input bit setm);
        vec_t v;
        v.name = name;
        v.key  = key;
        v.reps = reps;
        v.hh   = hh;
        v.mm   = mm;
        v.setm = setm;
        vecs.push_back(v);
    endtask

    task automatic pushExpect(input string name, input logic [15:0] e);
        exp_t x;
        x.name = name;
        x.exp  = e;
        sbQueue.push_back(x);
    endtask

    // Pops the oldest expectation and compares it against the live outputs.
    task automatic checkOutput();
        exp_t        x;
        logic [15:0] act;
        checks++;
        if (sbQueue.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no entry required one entry");
        end else begin
            x   = sbQueue.pop_front();
            act = outWord();
            if (act !== x.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %h required %h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic setTime(input int h, input int m, input int s);
        QHhour = 2'(h / 10);
        QLhour = 4'(h % 10);
        QHmin  = 3'(m / 10);
        QLmin  = 4'(m % 10);
        QHsec  = 3'(s / 10);
        QLsec  = 4'(s % 10);
    endtask

    // One press = key low for one clock, then three clocks for the
    // synchroniser, edge detect and commit; returns with the result visible.
    task automatic applyStimulus(input int code, input int reps);
        for (int r = 0; r < reps; r++) begin
            @(negedge CLK);
            case (code)
                K_SET:      KEY_SET  = 1'b0;
                K_HOUR:     KEY_HOUR = 1'b0;
                K_MIN:      KEY_MIN  = 1'b0;
                K_STOP:     KEY_STOP = 1'b0;
                K_SNZ:      KEY_SNZ  = 1'b0;
                K_HOUR_MIN: begin KEY_HOUR = 1'b0; KEY_MIN = 1'b0; end
                K_STOP_SNZ: begin KEY_STOP = 1'b0; KEY_SNZ = 1'b0; end
                default:    ;
            endcase
            @(negedge CLK);
            KEY_SET  = 1'b1;
            KEY_HOUR = 1'b1;
            KEY_MIN  = 1'b1;
            KEY_STOP = 1'b1;
            KEY_SNZ  = 1'b1;
            cycles(3);
        end
    endtask

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge CLK);
            EN1HZ = 1'b1;
            @(negedge CLK);
            EN1HZ = 1'b0;
        end
    endtask

    // Walks the time onto 07:30:00 and waits a bounded time for RING.
    task automatic triggerRing();
        setTime(7, 29, 59);
        @(negedge CLK);
        setTime(7, 30, 0);
        for (int w = 0; w < 3; w++) begin
            @(negedge CLK);
            if (RING) break;
        end
    endtask

    initial begin
        RST      = 1'b0;
        EN1HZ    = 1'b0;
        KEY_SET  = 1'b1;
        KEY_HOUR = 1'b1;
        KEY_MIN  = 1'b1;
        KEY_STOP = 1'b1;
        KEY_SNZ  = 1'b1;
        SW_ARM   = 1'b0;
        setTime(12, 34, 56);

        addVec("set_enter",     K_SET,      1,  0,  0, 1'b1);
        addVec("hour_x7",       K_HOUR,     7,  7,  0, 1'b1);
        addVec("min_x30",       K_MIN,      30, 7,  30, 1'b1);
        addVec("set_exit",      K_SET,      1,  7,  30, 1'b0);
        addVec("set_again",     K_SET,      1,  7,  30, 1'b1);
        addVec("hour_to_23",    K_HOUR,     16, 23, 30, 1'b1);
        addVec("hour_wrap",     K_HOUR,     1,  0,  30, 1'b1);
        addVec("hour_x5",       K_HOUR,     5,  5,  30, 1'b1);
        addVec("min_to_59",     K_MIN,      29, 5,  59, 1'b1);
        addVec("min_wrap",      K_MIN,      1,  5,  0,  1'b1);
        addVec("hour_min_both", K_HOUR_MIN, 2,  7,  2,  1'b1);
        addVec("min_x28",       K_MIN,      28, 7,  30, 1'b1);
        addVec("set_done",      K_SET,      1,  7,  30, 1'b0);

        cycles(3);
        pushExpect("reset_state", mkExp(0, 0, 0, 0, 0));
        checkOutput();
        RST = 1'b1;
        cycles(2);

        foreach (vecs[i]) begin
            pushExpect(vecs[i].name, mkExp(vecs[i].hh, vecs[i].mm, vecs[i].setm, 1'b0, 1'b0));
            applyStimulus(vecs[i].key, vecs[i].reps);
            checkOutput();
        end

        $display("[TB] ring timeout sequence");
        SW_ARM = 1'b1;
        cycles(3);
        pushExpect("ring_start", mkExp(7, 30, 0, 1, 0));
        triggerRing();
        checkOutput();
        pushExpect("ring_tick59", mkExp(7, 30, 0, 1, 0));
        tick(59);
        checkOutput();
        pushExpect("ring_timeout", mkExp(7, 30, 0, 0, 0));
        tick(1);
        checkOutput();

        $display("[TB] snooze sequence");
        pushExpect("ring_start2", mkExp(7, 30, 0, 1, 0));
        triggerRing();
        checkOutput();
        pushExpect("snooze_enter", mkExp(7, 30, 0, 0, 1));
        applyStimulus(K_SNZ, 1);
        checkOutput();
        pushExpect("snooze_tick299", mkExp(7, 30, 0, 0, 1));
        tick(299);
        checkOutput();
        pushExpect("snooze_rering", mkExp(7, 30, 0, 1, 0));
        tick(1);
        checkOutput();

        pushExpect("stop_and_snz", mkExp(7, 30, 0, 0, 0));
        applyStimulus(K_STOP_SNZ, 1);
        checkOutput();
        pushExpect("stop_and_snz_hold", mkExp(7, 30, 0, 0, 0));
        cycles(3);
        checkOutput();

        $display("[TB] set cancels ring");
        pushExpect("ring_start3", mkExp(7, 30, 0, 1, 0));
        triggerRing();
        checkOutput();
        pushExpect("ring_to_set", mkExp(7, 30, 1, 0, 0));
        applyStimulus(K_SET, 1);
        checkOutput();
        pushExpect("set_leave", mkExp(7, 30, 0, 0, 0));
        applyStimulus(K_SET, 1);
        checkOutput();

        $display("[TB] arm switch sequences");
        SW_ARM = 1'b0;
        cycles(3);
        pushExpect("disarmed_match", mkExp(7, 30, 0, 0, 0));
        triggerRing();
        cycles(2);
        checkOutput();
        SW_ARM = 1'b1;
        pushExpect("arm_at_match", mkExp(7, 30, 0, 0, 0));
        cycles(6);
        checkOutput();

        pushExpect("ring_start4", mkExp(7, 30, 0, 1, 0));
        triggerRing();
        checkOutput();
        pushExpect("snooze_enter2", mkExp(7, 30, 0, 0, 1));
        applyStimulus(K_SNZ, 1);
        checkOutput();
        pushExpect("disarm_in_snooze", mkExp(7, 30, 0, 0, 0));
        SW_ARM = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge CLK);
            if (!SNOOZING) break;
        end
        checkOutput();

        $display("[TB] reset while ringing");
        SW_ARM = 1'b1;
        cycles(3);
        pushExpect("ring_start5", mkExp(7, 30, 0, 1, 0));
        triggerRing();
        checkOutput();
        RST = 1'b0;
        #1;
        pushExpect("reset_mid_ring", mkExp(0, 0, 0, 0, 0));
        checkOutput();
        @(negedge CLK);
        RST = 1'b1;
        cycles(3);
        pushExpect("after_reset", mkExp(0, 0, 0, 0, 0));
        checkOutput();

        if (sbQueue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Alarm stage directly downstream of the sec/min/hour BCD time counters; consumes their digit outputs and the 1 Hz enable.
- Holds a user-set alarm time (HH:MM, BCD) and raises a ring output when the running time reaches HH:MM:00.
- Supports snooze, stop and auto-timeout.
- Exposes the alarm digits so the display mux can show them in set mode.

Parameters:
- RING_SECS, 60, ticks of EN1HZ before an unanswered ring auto-stops
- SNOOZE_SECS, 300, ticks of EN1HZ spent in snooze before re-ringing

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-low
- EN1HZ  in  1  one-cycle-wide tick, once per second, from prescaler
- QLsec  in  4  time seconds, ones digit (BCD 0-9)
- QHsec  in  3  time seconds, tens digit (0-5)
- QLmin  in  4  time minutes, ones digit
- QHmin  in  3  time minutes, tens digit
- QLhour  in  4  time hours, ones digit
- QHhour  in  2  time hours, tens digit (0-2)
- KEY_SET  in  1  raw button, active-low, pre-debounced; toggles set mode
- KEY_HOUR  in  1  raw button, active-low; alarm hour +1 in set mode
- KEY_MIN  in  1  raw button, active-low; alarm minute +1 in set mode
- KEY_STOP  in  1  raw button, active-low; stop ring/snooze
- KEY_SNZ  in  1  raw button, active-low; snooze
- SW_ARM  in  1  level switch, 1 = alarm armed
- ALQLmin  out  4  alarm minutes, ones digit
- ALQHmin  out  3  alarm minutes, tens digit
- ALQLhour  out  4  alarm hours, ones digit
- ALQHhour  out  2  alarm hours, tens digit
- SETMODE  out  1  1 while in SET state
- RING  out  1  1 while in RINGING state
- SNOOZING  out  1  1 while in SNOOZE state

Behaviour:
- Reset (RST=0, async): state IDLE; alarm = 00:00; all outputs 0; sync/edge flops cleared to released (1); second counter 0.
- Buttons:
  - Each KEY has a 2-FF synchroniser, then falling-edge detect producing a one-cycle press pulse.
  - KEY low on edge n gives the pulse in the cycle after edge n+2; the action is committed at edge n+3.
  - SW_ARM passes through a 2-FF synchroniser only.
- Match = (time H:M == alarm H:M) && QHsec==0 && QLsec==0, compared combinationally. A registered copy detects the match rising edge (match_rise).
- Alarm increment arithmetic:
  - Minute: BCD 00..59, 59 wraps to 00, no carry into hour.
  - Hour: BCD 00..23, 23 wraps to 00; 09 goes to 10, 19 goes to 20.
  - Both presses in the same cycle apply both increments.
- States and transitions:
  - IDLE
    - press SET -> SET
    - match_rise && arm -> RINGING, counter cleared
  - SET
    - press HOUR/MIN -> increment as above
    - press SET -> IDLE
    - match_rise ignored
  - RINGING
    - press STOP -> IDLE
    - else press SNZ -> SNOOZE, counter cleared
    - else press SET -> SET (ring cancelled)
    - else !arm -> IDLE
    - else on EN1HZ, counter+1; reaching RING_SECS -> IDLE
  - SNOOZE
    - press STOP, or !arm -> IDLE
    - press SET -> SET
    - else on EN1HZ, counter+1; reaching SNOOZE_SECS -> RINGING, counter cleared
    - match_rise ignored
- Priority on simultaneous events: STOP > SNZ > SET > !arm > timer expiry.
- Counter: 9 bits; cleared on every state entry.
- Outputs are registered (decoded from state and registers), with no combinational path from inputs.
- Alarm registers drive the AL* ports directly in all states.
- Arming while time already sits at HH:MM:00 does not ring; only a match rising edge triggers.

Test Plan:
- Reset mid-RINGING (RST low 1 cycle) -> RING=0, alarm 00:00, state IDLE on the same edge.
- SET press, 7 HOUR presses, 30 MIN presses, SET press -> AL digits 07:30, SETMODE 1 then 0. Further HOUR presses from 23 -> 00; MIN presses from 59 -> 00, hour unchanged.
- Alarm 07:30, arm=1, time steps 07:29:59 -> 07:30:00 -> RING=1 three cycles later at most; with no keys, RING drops after exactly 60 EN1HZ ticks.
- Ringing, SNZ press -> RING=0, SNOOZING=1; after 300 ticks -> RING=1, SNOOZING=0.
- Ringing, STOP and SNZ pressed in the same cycle -> IDLE, SNOOZING stays 0.
- arm=0 at match -> RING stays 0. Dropping arm during SNOOZE -> IDLE within 3 cycles.
